// File: rtl/alarm_defs_pkg.sv
// rtl/alarm_defs_pkg.sv - shared state encodings and defaults for the alarm controller
package alarm_defs;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } alarm_state_t;

  localparam int DEFAULT_SEC_DIV = 100000000;

  // Counter width that stays at least one bit for degenerate parameter values.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alarm_sec_tick.sv
// rtl/alarm_sec_tick.sv - SEC_DIV prescaler with synchronous clear, one-cycle sec_tick
module alarm_sec_tick
  import alarm_defs::*;
#(
  parameter int SEC_DIV = DEFAULT_SEC_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic sec_tick
);

  localparam int W = cnt_width(SEC_DIV);
  localparam logic [W-1:0] LAST = W'(SEC_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

  assign sec_tick = (cnt == LAST);

endmodule

// File: rtl/alarm_ctrl.sv
// rtl/alarm_ctrl.sv - alarm match, ring timeout, ack and snooze (snooze gated by ALARM_SNOOZE_EN)
module alarm_ctrl
  import alarm_defs::*;
#(
  parameter int SEC_DIV    = DEFAULT_SEC_DIV,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       time_valid,
  input  logic [7:0] rtc_hh,
  input  logic [7:0] rtc_mm,
  input  logic [7:0] al_hh,
  input  logic [7:0] al_mm,
  input  logic       alarm_en,
  input  logic       ack,
  input  logic       snooze,
  output logic       alarm_active,
  output logic       snoozing,
  output logic [1:0] st
);

  localparam int SEC_MAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int SEC_W   = cnt_width(SEC_MAX + 1);
  localparam logic [SEC_W-1:0] SEC_TOP   = SEC_W'(SEC_MAX);
  localparam logic [SEC_W-1:0] RING_LAST = SEC_W'(RING_SEC - 1);
  localparam logic [SEC_W-1:0] SNZ_LAST  = SEC_W'(SNOOZE_SEC - 1);

  alarm_state_t     state, next_state;
  logic             match_q, cmp, match_rise;
  logic             ack_q, ack_rise;
  logic             snooze_rise;
  logic             clear, sec_tick;
  logic [SEC_W-1:0] sec_cnt;
  logic             ring_done, snz_done;

  // Edge-based match so a minute fires once, and never when already matching.
  assign cmp        = (rtc_hh == al_hh) && (rtc_mm == al_mm);
  assign match_rise = time_valid & cmp & ~match_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      match_q <= 1'b1;
    end else if (time_valid) begin
      match_q <= cmp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_q <= 1'b1;
    end else begin
      ack_q <= ack;
    end
  end

  assign ack_rise = ack & ~ack_q;

`ifdef ALARM_SNOOZE_EN
  logic snooze_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      snooze_q <= 1'b1;
    end else begin
      snooze_q <= snooze;
    end
  end

  assign snooze_rise = snooze & ~snooze_q;
`else
  logic unused_snooze;

  assign unused_snooze = snooze;
  assign snooze_rise   = 1'b0;
`endif

  // Both timing counters restart on every state entry.
  assign clear = (next_state != state);

  alarm_sec_tick #(
    .SEC_DIV (SEC_DIV)
  ) u_sec_tick (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .sec_tick (sec_tick)
  );

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      sec_cnt <= '0;
    end else if (sec_tick && (sec_cnt != SEC_TOP)) begin
      sec_cnt <= sec_cnt + SEC_W'(1);
    end
  end

  assign ring_done = sec_tick && (sec_cnt == RING_LAST);
  assign snz_done  = sec_tick && (sec_cnt == SNZ_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!alarm_en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: next_state = ARMED;
        ARMED: begin
          if (match_rise) next_state = RINGING;
        end
        RINGING: begin
          if (ack_rise)         next_state = ARMED;
          else if (snooze_rise) next_state = SNOOZE;
          else if (ring_done)   next_state = ARMED;
        end
        SNOOZE: begin
          if (ack_rise)      next_state = ARMED;
          else if (snz_done) next_state = RINGING;
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      alarm_active <= 1'b0;
    end else begin
      alarm_active <= (next_state == RINGING);
    end
  end

`ifdef ALARM_SNOOZE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      snoozing <= 1'b0;
    end else begin
      snoozing <= (next_state == SNOOZE);
    end
  end
`else
  assign snoozing = 1'b0;
`endif

  assign st = state;

endmodule

// File: tb/tb_alarm_ctrl.sv
// tb/tb_alarm_ctrl.sv - directed self-checking bench for alarm_ctrl
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset, time_valid, alarm_en, ack, snooze;
  logic [7:0] rtc_hh, rtc_mm, al_hh, al_mm;
  logic       alarm_active, snoozing;
  logic [1:0] st;

  int checks = 0;
  int errors = 0;

  alarm_ctrl #(
    .SEC_DIV    (10),
    .RING_SEC   (3),
    .SNOOZE_SEC (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .time_valid   (time_valid),
    .rtc_hh       (rtc_hh),
    .rtc_mm       (rtc_mm),
    .al_hh        (al_hh),
    .al_mm        (al_mm),
    .alarm_en     (alarm_en),
    .ack          (ack),
    .snooze       (snooze),
    .alarm_active (alarm_active),
    .snoozing     (snoozing),
    .st           (st)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic strobe(input logic [7:0] hh, input logic [7:0] mm);
    time_valid = 1'b1;
    rtc_hh = hh;
    rtc_mm = mm;
    cyc(1);
    time_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; ack = 1'b1; snooze = 1'b1; alarm_en = 1'b0;
    cyc(2);
    checks++;
    if (alarm_active !== 1'b0 || snoozing !== 1'b0 || st !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs active=%b snoozing=%b st=%0d required 0 0 0", alarm_active, snoozing, st);
    end
    reset = 1'b0;
    cyc(1);
    checks++;
    if (st !== 2'd0) begin
      errors++;
      $display("FAIL idle_when_disabled st=%0d required 0", st);
    end
    ack = 1'b0; snooze = 1'b0;
    cyc(1);
  endtask

  task automatic test_fire;
    int n;
    alarm_en = 1'b1;
    cyc(1);
    checks++;
    if (st !== 2'd1) begin
      errors++;
      $display("FAIL armed_after_enable st=%0d required 1", st);
    end
    strobe(8'h07, 8'h29);
    checks++;
    if (alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL no_fire_0729 active=%b required 0", alarm_active);
    end
    strobe(8'h07, 8'h30);
    checks++;
    if (alarm_active !== 1'b1 || st !== 2'd2) begin
      errors++;
      $display("FAIL fire_0730 active=%b st=%0d required 1 2", alarm_active, st);
    end
    n = 0;
    while (alarm_active === 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n !== 30) begin
      errors++;
      $display("FAIL ring_length cycles=%0d required 30", n);
    end
    checks++;
    if (st !== 2'd1) begin
      errors++;
      $display("FAIL timeout_to_armed st=%0d required 1", st);
    end
  endtask

  task automatic test_ack;
    strobe(8'h07, 8'h31);
    strobe(8'h07, 8'h30);
    cyc(4);
    ack = 1'b1;
    cyc(1);
    checks++;
    if (alarm_active !== 1'b0 || st !== 2'd1) begin
      errors++;
      $display("FAIL ack_stops active=%b st=%0d required 0 1", alarm_active, st);
    end
    ack = 1'b0;
    strobe(8'h07, 8'h30);
    strobe(8'h07, 8'h30);
    checks++;
    if (alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL no_refire_same_minute active=%b required 0", alarm_active);
    end
    strobe(8'h07, 8'h31);
    strobe(8'h07, 8'h30);
    checks++;
    if (alarm_active !== 1'b1) begin
      errors++;
      $display("FAIL refire_after_change active=%b required 1", alarm_active);
    end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(1);
  endtask

  task automatic test_snooze;
    int n;
    strobe(8'h07, 8'h31);
    strobe(8'h07, 8'h30);
    cyc(2);
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
`ifdef ALARM_SNOOZE_EN
    checks++;
    if (alarm_active !== 1'b0 || snoozing !== 1'b1 || st !== 2'd3) begin
      errors++;
      $display("FAIL snooze_enter active=%b snoozing=%b st=%0d required 0 1 3", alarm_active, snoozing, st);
    end
    n = 0;
    while (snoozing === 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n !== 20) begin
      errors++;
      $display("FAIL snooze_length cycles=%0d required 20", n);
    end
    n = 0;
    while (alarm_active === 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n !== 30) begin
      errors++;
      $display("FAIL reRing_length cycles=%0d required 30", n);
    end
`else
    checks++;
    if (alarm_active !== 1'b1 || snoozing !== 1'b0 || st !== 2'd2) begin
      errors++;
      $display("FAIL snooze_ignored active=%b snoozing=%b st=%0d required 1 0 2", alarm_active, snoozing, st);
    end
    n = 0;
    while (alarm_active === 1'b1 && n < 200) begin
      cyc(1);
      n++;
    end
    checks++;
    if (n !== 27) begin
      errors++;
      $display("FAIL ring_rest_after_snooze cycles=%0d required 27", n);
    end
`endif
    checks++;
    if (st !== 2'd1) begin
      errors++;
      $display("FAIL snooze_cycle_end st=%0d required 1", st);
    end
  endtask

  task automatic test_disable;
    strobe(8'h07, 8'h31);
    strobe(8'h07, 8'h30);
    cyc(3);
    alarm_en = 1'b0;
    cyc(1);
    checks++;
    if (st !== 2'd0 || alarm_active !== 1'b0 || snoozing !== 1'b0) begin
      errors++;
      $display("FAIL disable_mid_ring st=%0d active=%b snoozing=%b required 0 0 0", st, alarm_active, snoozing);
    end
`ifdef ALARM_SNOOZE_EN
    alarm_en = 1'b1;
    cyc(1);
    strobe(8'h07, 8'h31);
    strobe(8'h07, 8'h30);
    snooze = 1'b1;
    cyc(1);
    snooze = 1'b0;
    cyc(3);
    alarm_en = 1'b0;
    cyc(1);
    checks++;
    if (st !== 2'd0 || alarm_active !== 1'b0 || snoozing !== 1'b0) begin
      errors++;
      $display("FAIL disable_mid_snooze st=%0d active=%b snoozing=%b required 0 0 0", st, alarm_active, snoozing);
    end
`endif
    strobe(8'h07, 8'h30);
    alarm_en = 1'b1;
    cyc(1);
    strobe(8'h07, 8'h30);
    checks++;
    if (alarm_active !== 1'b0 || st !== 2'd1) begin
      errors++;
      $display("FAIL reenable_in_match active=%b st=%0d required 0 1", alarm_active, st);
    end
  endtask

  task automatic test_reset_mid;
    strobe(8'h07, 8'h31);
    strobe(8'h07, 8'h30);
    cyc(2);
    reset = 1'b1;
    cyc(1);
    checks++;
    if (alarm_active !== 1'b0 || snoozing !== 1'b0 || st !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid_ring active=%b snoozing=%b st=%0d required 0 0 0", alarm_active, snoozing, st);
    end
    reset = 1'b0;
    cyc(1);
    strobe(8'h07, 8'h30);
    checks++;
    if (alarm_active !== 1'b0 || st !== 2'd1) begin
      errors++;
      $display("FAIL first_sample_after_reset active=%b st=%0d required 0 1", alarm_active, st);
    end
  endtask

  task automatic test_both;
    strobe(8'h07, 8'h31);
    strobe(8'h07, 8'h30);
    cyc(1);
    ack = 1'b1;
    snooze = 1'b1;
    cyc(1);
    checks++;
    if (st !== 2'd1 || snoozing !== 1'b0 || alarm_active !== 1'b0) begin
      errors++;
      $display("FAIL ack_beats_snooze st=%0d snoozing=%b active=%b required 1 0 0", st, snoozing, alarm_active);
    end
    ack = 1'b0;
    snooze = 1'b0;
    cyc(1);
  endtask

  task automatic test_alarm_change;
    al_mm = 8'h45;
    strobe(8'h07, 8'h44);
    strobe(8'h07, 8'h45);
    checks++;
    if (alarm_active !== 1'b1) begin
      errors++;
      $display("FAIL new_alarm_time active=%b required 1", alarm_active);
    end
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1; time_valid = 1'b0; alarm_en = 1'b0; ack = 1'b0; snooze = 1'b0;
    rtc_hh = 8'h00; rtc_mm = 8'h00; al_hh = 8'h07; al_mm = 8'h30;
    #1;
    test_reset;
    test_fire;
    test_ack;
    test_snooze;
    test_disable;
    test_reset_mid;
    test_both;
    test_alarm_change;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
